// File: rtl/accumulator64.sv
// accumulator64: 64-bit accumulator stage around a FullAdder64 ripple adder.
// Operand transactions arrive on a valid/ready handshake; ADD/SUB results are
// captured from the adder after a SETTLE_CYCLES-long settle window, and the
// result is offered downstream on a second valid/ready handshake.
// Optional build macro: ACC_SATURATE_EN clamps Acc on signed overflow
// instead of wrapping.

// One 4-bit ripple slice of the long adder.
module FullAdder4 (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       CarryIn,
    output logic [3:0] Sum,
    output logic       CarryOut
);
    logic [4:0] c;

    assign c[0] = CarryIn;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign Sum[i]   = X[i] ^ Y[i] ^ c[i];
        assign c[i + 1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
    end

    assign CarryOut = c[4];
endmodule

// 64-bit ripple adder built from sixteen chained 4-bit slices.
module FullAdder64 (
    input  logic [63:0] X,
    input  logic [63:0] Y,
    input  logic        CarryIn,
    output logic [63:0] Sum,
    output logic        CarryOut
);
    logic [16:0] chain;

    assign chain[0] = CarryIn;

    for (genvar s = 0; s < 16; s++) begin : g_slice
        FullAdder4 u_slice (
            .X        (X[4*s +: 4]),
            .Y        (Y[4*s +: 4]),
            .CarryIn  (chain[s]),
            .Sum      (Sum[4*s +: 4]),
            .CarryOut (chain[s + 1])
        );
    end

    assign CarryOut = chain[16];
endmodule

// Accumulator stage: handshake control, registered adder drive, result capture.
module accumulator64 #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [63:0] ACC_INIT      = 64'h0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [1:0]  Op,
    input  logic [63:0] Operand,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [63:0] Acc,
    output logic        CarryFlag,
    output logic        OverflowFlag,
    output logic        ZeroFlag,
    output logic        NegFlag
);
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [3:0]  CNT_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [63:0] SAT_MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SAT_MIN  = 64'h8000_0000_0000_0000;

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] adder_x;
    logic [63:0] adder_y;
    logic        adder_cin;
    logic [63:0] sum;
    logic        carry_out;
    logic        sum_ovf;
    logic [63:0] capture_value;

    // The adder only ever sees registered inputs, so its ripple chain has the
    // whole settle window rather than a single clock period.
    FullAdder64 u_adder (
        .X        (adder_x),
        .Y        (adder_y),
        .CarryIn  (adder_cin),
        .Sum      (sum),
        .CarryOut (carry_out)
    );

    // Signed overflow detection and the value Acc takes at an ADD/SUB capture.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        capture_value = sum;
        sum_ovf       = (adder_x[63] == adder_y[63]) && (sum[63] != adder_x[63]);
`ifdef ACC_SATURATE_EN
        if (sum_ovf) begin
            capture_value = adder_x[63] ? SAT_MIN : SAT_MAX;
        end
`else
        capture_value = sum;
`endif
    end

    // Control FSM plus every registered output; Acc changes only at LOAD/CLEAR
    // acceptance and at the end of the settle window.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            adder_x      <= '0;
            adder_y      <= '0;
            adder_cin    <= 1'b0;
            Acc          <= ACC_INIT;
            ZeroFlag     <= (ACC_INIT == 64'h0);
            NegFlag      <= ACC_INIT[63];
            CarryFlag    <= 1'b0;
            OverflowFlag <= 1'b0;
            OutValid     <= 1'b0;
            InReady      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!InReady) begin
                        // First idle cycle after reset: open the input port.
                        InReady <= 1'b1;
                    end else if (InValid) begin
                        InReady <= 1'b0;
                        adder_x <= Acc;
                        case (Op)
                            OP_LOAD: begin
                                Acc          <= Operand;
                                ZeroFlag     <= (Operand == 64'h0);
                                NegFlag      <= Operand[63];
                                CarryFlag    <= 1'b0;
                                OverflowFlag <= 1'b0;
                                OutValid     <= 1'b1;
                                state        <= HOLD;
                            end
                            OP_CLEAR: begin
                                Acc          <= ACC_INIT;
                                ZeroFlag     <= (ACC_INIT == 64'h0);
                                NegFlag      <= ACC_INIT[63];
                                CarryFlag    <= 1'b0;
                                OverflowFlag <= 1'b0;
                                OutValid     <= 1'b1;
                                state        <= HOLD;
                            end
                            OP_ADD: begin
                                adder_y   <= Operand;
                                adder_cin <= 1'b0;
                                cnt       <= CNT_LOAD;
                                state     <= SETTLE;
                            end
                            default: begin
                                // SUB: two's complement via inverted operand plus carry-in.
                                adder_y   <= ~Operand;
                                adder_cin <= 1'b1;
                                cnt       <= CNT_LOAD;
                                state     <= SETTLE;
                            end
                        endcase
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) begin
                        Acc          <= capture_value;
                        ZeroFlag     <= (capture_value == 64'h0);
                        NegFlag      <= capture_value[63];
                        CarryFlag    <= carry_out;
                        OverflowFlag <= sum_ovf;
                        OutValid     <= 1'b1;
                        state        <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        InReady  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_accumulator64.sv
// Self-checking bench for accumulator64: directed vectors with literal
// expectations, plus a transaction-level model compared on every cycle.
module tb_accumulator64;
    localparam int          SETTLE = 2;
    localparam logic [63:0] INIT   = 64'h0;
    localparam logic [1:0]  LOAD   = 2'b00;
    localparam logic [1:0]  ADD    = 2'b01;
    localparam logic [1:0]  SUB    = 2'b10;
    localparam logic [1:0]  CLEAR  = 2'b11;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [1:0]  Op = 2'b00;
    logic [63:0] Operand = 64'h0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [63:0] Acc;
    logic        CarryFlag;
    logic        OverflowFlag;
    logic        ZeroFlag;
    logic        NegFlag;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    accumulator64 #(
        .SETTLE_CYCLES (SETTLE),
        .ACC_INIT      (INIT)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .InValid      (InValid),
        .InReady      (InReady),
        .Op           (Op),
        .Operand      (Operand),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .Acc          (Acc),
        .CarryFlag    (CarryFlag),
        .OverflowFlag (OverflowFlag),
        .ZeroFlag     (ZeroFlag),
        .NegFlag      (NegFlag)
    );

    always #5 Clock = ~Clock;

    // Count rising edges; at a falling edge cyc is the number of edges so far.
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          chk_en = 1'b0;
    bit          m_pending = 1'b0;
    int          m_accept_edge = 0;
    int          m_ready_edge  = 0;
    int          m_open_edge   = 1 << 30;
    logic [63:0] m_acc = INIT;
    logic        m_c = 1'b0;
    logic        m_v = 1'b0;
    logic [63:0] m_new;
    logic        m_newc;
    logic        m_newv;

    function automatic void model_op(input logic [1:0] op, input logic [63:0] a,
                                     input logic [63:0] b, output logic [63:0] r,
                                     output logic c, output logic v);
        r = INIT;
        c = 1'b0;
        v = 1'b0;
        case (op)
            LOAD: r = b;
            ADD: begin
                r = a + b;
                c = (r < a);
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            SUB: begin
                r = a - b;
                c = (a >= b);
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            default: r = INIT;
        endcase
`ifdef ACC_SATURATE_EN
        if (v) r = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    endfunction

    // Per-cycle compare of every output against the model.
    logic        e_txn;
    logic        e_valid;
    logic        e_rdy;
    logic [63:0] e_acc;
    logic        e_c;
    logic        e_v;

    initial begin
        forever begin
            @(negedge Clock);
            #1;
            if (chk_en) begin
                e_txn   = m_pending && (cyc >= m_accept_edge);
                e_valid = e_txn && (cyc >= m_ready_edge);
                e_rdy   = !e_txn && (cyc >= m_open_edge);
                e_acc   = e_valid ? m_new  : m_acc;
                e_c     = e_valid ? m_newc : m_c;
                e_v     = e_valid ? m_newv : m_v;
                check("cmp_out_valid", OutValid, e_valid);
                check("cmp_in_ready", InReady, e_rdy);
                check("cmp_acc", Acc, e_acc);
                check("cmp_carry", CarryFlag, e_c);
                check("cmp_overflow", OverflowFlag, e_v);
                check("cmp_zero", ZeroFlag, e_acc == 64'h0);
                check("cmp_neg", NegFlag, e_acc[63]);
                if (e_valid && OutReady) begin
                    m_acc     = m_new;
                    m_c       = m_newc;
                    m_v       = m_newv;
                    m_pending = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus tasks (all start and end on a falling edge) ----------------
    task automatic do_reset();
        chk_en  = 1'b0;
        Reset   = 1'b1;
        InValid = 1'b0;
        @(negedge Clock);
        m_pending   = 1'b0;
        m_acc       = INIT;
        m_c         = 1'b0;
        m_v         = 1'b0;
        m_open_edge = 1 << 30;
        chk_en      = 1'b1;
        check("rst_acc", Acc, INIT);
        check("rst_out_valid", OutValid, 1'b0);
        check("rst_in_ready", InReady, 1'b0);
        check("rst_zero", ZeroFlag, 1'b1);
        @(negedge Clock);
        Reset       = 1'b0;
        m_open_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            Op      = 2'($urandom);
            Operand = {$urandom, $urandom};
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [63:0] opnd, output int waited);
        Op      = op;
        Operand = opnd;
        InValid = 1'b1;
        waited  = 0;
        while (InReady !== 1'b1 && waited < 50) begin
            @(negedge Clock);
            waited++;
        end
        if (InReady !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: InReady %b after %0d cycles, required 1", InReady, waited);
            InValid = 1'b0;
        end else begin
            model_op(op, m_acc, opnd, m_new, m_newc, m_newv);
            m_accept_edge = cyc + 1;
            m_ready_edge  = cyc + 1 + ((op == ADD || op == SUB) ? SETTLE : 0);
            m_pending     = 1'b1;
            @(negedge Clock);
            InValid = 1'b0;
            Op      = 2'($urandom);
            Operand = {$urandom, $urandom};
        end
    endtask

    task automatic expect_result(input string name, input int lat_exp, input logic [63:0] acc_exp,
                                 input logic c_exp, input logic v_exp, input logic z_exp,
                                 input logic n_exp, input int stall);
        int lat;
        lat = 1;
        while (OutValid !== 1'b1 && lat < 40) begin
            @(negedge Clock);
            lat++;
        end
        check({name, "_latency"}, lat, lat_exp);
        check({name, "_acc"}, Acc, acc_exp);
        check({name, "_carry"}, CarryFlag, c_exp);
        check({name, "_overflow"}, OverflowFlag, v_exp);
        check({name, "_zero"}, ZeroFlag, z_exp);
        check({name, "_neg"}, NegFlag, n_exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge Clock);
            if (i == 3) begin
                InValid = 1'b1;
                Op      = LOAD;
                Operand = 64'hBAD0_BAD0_BAD0_BAD0;
            end else begin
                InValid = 1'b0;
            end
        end
        if (stall > 0) begin
            check({name, "_stall_valid"}, OutValid, 1'b1);
            check({name, "_stall_acc"}, Acc, acc_exp);
            check({name, "_stall_in_ready"}, InReady, 1'b0);
        end
        OutReady = 1'b1;
        @(negedge Clock);
        OutReady = 1'b0;
        check({name, "_valid_drop"}, OutValid, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        do_reset();

        issue(LOAD, 64'h5, w);
        expect_result("load5", 1, 64'h5, 0, 0, 0, 0, 0);
        issue(ADD, 64'h3, w);
        expect_result("add3", SETTLE + 1, 64'h8, 0, 0, 0, 0, 0);
        idle(3);

        issue(LOAD, 64'hFFFF_FFFF_FFFF_FFFF, w);
        expect_result("load_ones", 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0);
        issue(ADD, 64'h1, w);
        expect_result("add_full_carry", SETTLE + 1, 64'h0, 1, 0, 1, 0, 0);

        issue(LOAD, 64'h7FFF_FFFF_FFFF_FFFF, w);
        expect_result("load_max", 1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0);
        issue(ADD, 64'h1, w);
`ifdef ACC_SATURATE_EN
        expect_result("add_ovf", SETTLE + 1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0);
`else
        expect_result("add_ovf", SETTLE + 1, 64'h8000_0000_0000_0000, 0, 1, 0, 1, 0);
`endif

        issue(LOAD, 64'h3, w);
        expect_result("load3", 1, 64'h3, 0, 0, 0, 0, 0);
        issue(SUB, 64'h5, w);
        expect_result("sub_borrow", SETTLE + 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1, 0);
        issue(LOAD, 64'h3, w);
        expect_result("reload3", 1, 64'h3, 0, 0, 0, 0, 0);
        issue(SUB, 64'h3, w);
        expect_result("sub_zero", SETTLE + 1, 64'h0, 1, 0, 1, 0, 0);

        issue(LOAD, 64'h8000_0000_0000_0000, w);
        expect_result("load_min", 1, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 0);
        issue(SUB, 64'h1, w);
`ifdef ACC_SATURATE_EN
        expect_result("sub_ovf", SETTLE + 1, 64'h8000_0000_0000_0000, 1, 1, 0, 1, 0);
`else
        expect_result("sub_ovf", SETTLE + 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 0);
`endif

        issue(LOAD, 64'h0123_4567_89AB_CDEF, w);
        expect_result("load_pat", 1, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0);
        issue(ADD, 64'hFEDC_BA98_7654_3210, w);
        expect_result("add_pat", SETTLE + 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0);
        issue(SUB, 64'hFFFF_FFFF_FFFF_FFFF, w);
        expect_result("sub_self", SETTLE + 1, 64'h0, 1, 0, 1, 0, 0);

        issue(LOAD, 64'h1234, w);
        expect_result("load_1234", 1, 64'h1234, 0, 0, 0, 0, 0);
        idle(2);
        issue(CLEAR, 64'hDEAD_BEEF_DEAD_BEEF, w);
        expect_result("clear", 1, INIT, 0, 0, 1, 0, 0);

        // Backpressure: ten stalled cycles with an ignored InValid pulse, then back-to-back issue.
        issue(LOAD, 64'd10, w);
        expect_result("bp_load", 1, 64'd10, 0, 0, 0, 0, 0);
        issue(ADD, 64'd20, w);
        expect_result("bp_add", SETTLE + 1, 64'd30, 0, 0, 0, 0, 10);
        issue(ADD, 64'd1, w);
        check("bp_next_accept_wait", w, 0);
        expect_result("bp_add_next", SETTLE + 1, 64'd31, 0, 0, 0, 0, 0);

        // Reset while an ADD is settling: the result must never appear.
        issue(ADD, 64'd7, w);
        do_reset();
        idle(6);
        check("rst_mid_no_result", OutValid, 1'b0);
        check("rst_mid_acc", Acc, INIT);

        issue(LOAD, 64'h9, w);
        expect_result("post_rst_load", 1, 64'h9, 0, 0, 0, 0, 0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end
endmodule
